// File: rtl/id_ex_alu_feed_if.sv
// EX-stage operand/select bundle leaving the ID/EX register.
// master: the pipeline register that drives it; slave: the ALU / MEM side that reads it.
interface id_ex_alu_feed_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic [DW-1:0] EX_rd1;
  logic [DW-1:0] EX_alu_in2;
  logic [2:0]    EX_alu_select;
  logic [DW-1:0] EX_rd2;
  logic          EX_valid;
  logic [RW-1:0] EX_dst;
  logic          EX_regwrite;
  logic          EX_illegal;

  modport master (
    output EX_rd1, EX_alu_in2, EX_alu_select, EX_rd2,
           EX_valid, EX_dst, EX_regwrite, EX_illegal
  );

  modport slave (
    input  EX_rd1, EX_alu_in2, EX_alu_select, EX_rd2,
           EX_valid, EX_dst, EX_regwrite, EX_illegal
  );
endinterface

// File: rtl/id_ex_alu_feed.sv
// ID/EX pipeline register feeding the execute-stage ALU.
// Captures decoded operands/control, decodes the 3-bit ALU select, extends the
// immediate and applies the ALUSrc mux on the EX side.
// Optional feature: define FORWARDING_EN to add MEM/WB operand forwarding after
// the EX register (MEM has priority over WB, register $0 never forwarded).
module id_ex_alu_feed #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          ID_valid,
  input  logic [DW-1:0] ID_rd1,
  input  logic [DW-1:0] ID_rd2,
  input  logic [15:0]   ID_imm16,
  input  logic [1:0]    ID_aluop,
  input  logic [5:0]    ID_funct,
  input  logic          ID_alusrc,
  input  logic [RW-1:0] ID_rs,
  input  logic [RW-1:0] ID_rt,
  input  logic [RW-1:0] ID_dst,
  input  logic          ID_regwrite,
  input  logic          MEM_regwrite,
  input  logic [RW-1:0] MEM_dst,
  input  logic [DW-1:0] MEM_result,
  input  logic          WB_regwrite,
  input  logic [RW-1:0] WB_dst,
  input  logic [DW-1:0] WB_result,
  id_ex_alu_feed_if.master ex
);

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

  // EX register state
  logic          valid_q,    valid_d;
  logic          regwrite_q, regwrite_d;
  logic          illegal_q,  illegal_d;
  logic [2:0]    sel_q,      sel_d;
  logic          alusrc_q,   alusrc_d;
  logic [DW-1:0] rd1_q,      rd1_d;
  logic [DW-1:0] rd2_q,      rd2_d;
  logic [DW-1:0] imm_q,      imm_d;
  logic [RW-1:0] rs_q,       rs_d;
  logic [RW-1:0] rt_q,       rt_d;
  logic [RW-1:0] dst_q,      dst_d;

  // Decoded ID-side values
  logic [2:0]    dec_sel;
  logic          dec_illegal;
  logic [DW-1:0] dec_imm;

  // Decode ALUOp/funct into the ALU select and extend the immediate
  always_comb begin
    dec_sel     = SEL_ADD;
    dec_illegal = 1'b0;
    case (ID_aluop)
      2'b00: dec_sel = SEL_ADD;
      2'b01: dec_sel = SEL_SUB;
      2'b11: dec_sel = SEL_OR;
      default: begin
        case (ID_funct)
          6'b100000: dec_sel = SEL_ADD;
          6'b100010: dec_sel = SEL_SUB;
          6'b100100: dec_sel = SEL_AND;
          6'b100101: dec_sel = SEL_OR;
          6'b101010: dec_sel = SEL_SLT;
          default: begin
            dec_sel     = SEL_ADD;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
    // ori uses a logical immediate; everything else is arithmetic
    if (ID_aluop == 2'b11) begin
      dec_imm = {{(DW-16){1'b0}}, ID_imm16};
    end else begin
      dec_imm = {{(DW-16){ID_imm16[15]}}, ID_imm16};
    end
  end

  // Next-state: flush beats stall beats load; an invalid ID slot loads a bubble
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    illegal_d  = illegal_q;
    sel_d      = sel_q;
    alusrc_d   = alusrc_q;
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    dst_d      = dst_q;
    if (flush || (!stall && !ID_valid)) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      illegal_d  = 1'b0;
      sel_d      = SEL_ADD;
      alusrc_d   = 1'b0;
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      rs_d       = '0;
      rt_d       = '0;
      dst_d      = '0;
    end else if (!stall) begin
      valid_d    = 1'b1;
      regwrite_d = ID_regwrite;
      illegal_d  = dec_illegal;
      sel_d      = dec_sel;
      alusrc_d   = ID_alusrc;
      rd1_d      = ID_rd1;
      rd2_d      = ID_rd2;
      imm_d      = dec_imm;
      rs_d       = ID_rs;
      rt_d       = ID_rt;
      dst_d      = ID_dst;
    end
  end

  // EX register; reset state is a bubble with the ADD select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
      sel_q      <= SEL_ADD;
      alusrc_q   <= 1'b0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dst_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      illegal_q  <= illegal_d;
      sel_q      <= sel_d;
      alusrc_q   <= alusrc_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dst_q      <= dst_d;
    end
  end

  logic [DW-1:0] fwd_rs;
  logic [DW-1:0] fwd_rt;

`ifdef FORWARDING_EN
  // Forward live MEM/WB results onto captured operands; MEM is the younger producer
  always_comb begin
    fwd_rs = rd1_q;
    fwd_rt = rd2_q;
    if (MEM_regwrite && (MEM_dst == rs_q) && (rs_q != '0)) begin
      fwd_rs = MEM_result;
    end else if (WB_regwrite && (WB_dst == rs_q) && (rs_q != '0)) begin
      fwd_rs = WB_result;
    end
    if (MEM_regwrite && (MEM_dst == rt_q) && (rt_q != '0)) begin
      fwd_rt = MEM_result;
    end else if (WB_regwrite && (WB_dst == rt_q) && (rt_q != '0)) begin
      fwd_rt = WB_result;
    end
  end
`else
  // No forwarding: operands come straight from the EX register
  always_comb begin
    fwd_rs = rd1_q;
    fwd_rt = rd2_q;
  end

  // Forwarding-only inputs and specifiers are intentionally left unconnected
  logic unused_fwd;
  assign unused_fwd = ^{MEM_regwrite, MEM_dst, MEM_result,
                        WB_regwrite, WB_dst, WB_result, rs_q, rt_q};
`endif

  // Drive the EX-side bundle, applying the ALUSrc mux on operand B
  always_comb begin
    ex.EX_rd1        = fwd_rs;
    ex.EX_alu_in2    = alusrc_q ? imm_q : fwd_rt;
    ex.EX_rd2        = fwd_rt;
    ex.EX_alu_select = sel_q;
    ex.EX_valid      = valid_q;
    ex.EX_dst        = dst_q;
    ex.EX_regwrite   = regwrite_q;
    ex.EX_illegal    = illegal_q;
  end

endmodule

// File: tb/tb_id_ex_alu_feed.sv
// Directed bench for id_ex_alu_feed: hand-computed vectors, one line per check failure.
module tb_id_ex_alu_feed;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          ID_valid = 1'b0;
  logic [DW-1:0] ID_rd1 = '0;
  logic [DW-1:0] ID_rd2 = '0;
  logic [15:0]   ID_imm16 = '0;
  logic [1:0]    ID_aluop = '0;
  logic [5:0]    ID_funct = '0;
  logic          ID_alusrc = 1'b0;
  logic [RW-1:0] ID_rs = '0;
  logic [RW-1:0] ID_rt = '0;
  logic [RW-1:0] ID_dst = '0;
  logic          ID_regwrite = 1'b0;
  logic          MEM_regwrite = 1'b0;
  logic [RW-1:0] MEM_dst = '0;
  logic [DW-1:0] MEM_result = '0;
  logic          WB_regwrite = 1'b0;
  logic [RW-1:0] WB_dst = '0;
  logic [DW-1:0] WB_result = '0;

  int total = 0;
  int bad = 0;

  id_ex_alu_feed_if #(.DW(DW), .RW(RW)) ex_if ();

  id_ex_alu_feed #(.DW(DW), .RW(RW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .ID_valid     (ID_valid),
    .ID_rd1       (ID_rd1),
    .ID_rd2       (ID_rd2),
    .ID_imm16     (ID_imm16),
    .ID_aluop     (ID_aluop),
    .ID_funct     (ID_funct),
    .ID_alusrc    (ID_alusrc),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_dst       (ID_dst),
    .ID_regwrite  (ID_regwrite),
    .MEM_regwrite (MEM_regwrite),
    .MEM_dst      (MEM_dst),
    .MEM_result   (MEM_result),
    .WB_regwrite  (WB_regwrite),
    .WB_dst       (WB_dst),
    .WB_result    (WB_result),
    .ex           (ex_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_id(input logic [31:0] rd1, input logic [31:0] rd2,
                         input logic [15:0] imm, input logic [1:0] aluop,
                         input logic [5:0] funct, input logic alusrc);
    ID_valid  = 1'b1;
    ID_rd1    = rd1;
    ID_rd2    = rd2;
    ID_imm16  = imm;
    ID_aluop  = aluop;
    ID_funct  = funct;
    ID_alusrc = alusrc;
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_valid", 32'(ex_if.EX_valid), 32'd0);
    check_val("rst_sel",   32'(ex_if.EX_alu_select), 32'd2);
    check_val("rst_rd1",   ex_if.EX_rd1, 32'd0);
    check_val("rst_in2",   ex_if.EX_alu_in2, 32'd0);
    check_val("rst_rd2",   ex_if.EX_rd2, 32'd0);
    step();
    step();
    rst_n = 1'b1;

    // R-type sub
    load_id(32'd10, 32'd12, 16'h0000, 2'b10, 6'b100010, 1'b0);
    ID_regwrite = 1'b1;
    ID_dst = 5'd3;
    step();
    check_val("sub_rd1",   ex_if.EX_rd1, 32'd10);
    check_val("sub_in2",   ex_if.EX_alu_in2, 32'd12);
    check_val("sub_sel",   32'(ex_if.EX_alu_select), 32'd6);
    check_val("sub_valid", 32'(ex_if.EX_valid), 32'd1);
    check_val("sub_rw",    32'(ex_if.EX_regwrite), 32'd1);
    check_val("sub_dst",   32'(ex_if.EX_dst), 32'd3);

    // R-type and / slt
    load_id(32'd1, 32'd2, 16'h0000, 2'b10, 6'b100100, 1'b0);
    step();
    check_val("and_sel", 32'(ex_if.EX_alu_select), 32'd0);
    load_id(32'd1, 32'd2, 16'h0000, 2'b10, 6'b101010, 1'b0);
    step();
    check_val("slt_sel", 32'(ex_if.EX_alu_select), 32'd7);

    // Sign-extended immediate, then zero-extended for ori
    load_id(32'd10, 32'd12, 16'hFFFE, 2'b00, 6'b000000, 1'b1);
    step();
    check_val("sext_in2", ex_if.EX_alu_in2, 32'hFFFFFFFE);
    check_val("sext_sel", 32'(ex_if.EX_alu_select), 32'd2);
    check_val("sext_rd2", ex_if.EX_rd2, 32'd12);
    load_id(32'd10, 32'd12, 16'hFFFE, 2'b11, 6'b000000, 1'b1);
    step();
    check_val("zext_in2", ex_if.EX_alu_in2, 32'h0000FFFE);
    check_val("zext_sel", 32'(ex_if.EX_alu_select), 32'd1);

    // Stall three cycles with changing ID inputs: outputs hold
    stall = 1'b1;
    load_id(32'd99, 32'd98, 16'h0001, 2'b01, 6'b000000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("stall_rd1", ex_if.EX_rd1, 32'd10);
      check_val("stall_in2", ex_if.EX_alu_in2, 32'h0000FFFE);
      check_val("stall_sel", 32'(ex_if.EX_alu_select), 32'd1);
    end
    // Flush wins over stall
    flush = 1'b1;
    step();
    check_val("flush_valid", 32'(ex_if.EX_valid), 32'd0);
    check_val("flush_rw",    32'(ex_if.EX_regwrite), 32'd0);
    check_val("flush_sel",   32'(ex_if.EX_alu_select), 32'd2);
    check_val("flush_rd1",   ex_if.EX_rd1, 32'd0);
    flush = 1'b0;
    stall = 1'b0;

    // aluop=01 sub
    step();
    check_val("subi_sel", 32'(ex_if.EX_alu_select), 32'd6);
    check_val("subi_in2", ex_if.EX_rd2, 32'd98);

    // Illegal funct, then a bubble clears it
    load_id(32'd4, 32'd5, 16'h0000, 2'b10, 6'b000111, 1'b0);
    step();
    check_val("ill_sel", 32'(ex_if.EX_alu_select), 32'd2);
    check_val("ill_flag", 32'(ex_if.EX_illegal), 32'd1);
    ID_valid = 1'b0;
    step();
    check_val("ill_clr", 32'(ex_if.EX_illegal), 32'd0);
    check_val("bub_valid", 32'(ex_if.EX_valid), 32'd0);
    check_val("bub_rw", 32'(ex_if.EX_regwrite), 32'd0);

    // Forwarding: MEM and WB both match rs=5
    load_id(32'd100, 32'd200, 16'h0000, 2'b10, 6'b100000, 1'b0);
    ID_rs = 5'd5;
    ID_rt = 5'd6;
    MEM_regwrite = 1'b1; MEM_dst = 5'd5; MEM_result = 32'd7;
    WB_regwrite  = 1'b1; WB_dst  = 5'd5; WB_result  = 32'd9;
    step();
`ifdef FORWARDING_EN
    check_val("fwd_mem", ex_if.EX_rd1, 32'd7);
`else
    check_val("fwd_mem", ex_if.EX_rd1, 32'd100);
`endif
    check_val("fwd_rt_none", ex_if.EX_alu_in2, 32'd200);
    // Forwarding tracks live MEM/WB inputs combinationally
    MEM_regwrite = 1'b0;
    #1;
`ifdef FORWARDING_EN
    check_val("fwd_wb", ex_if.EX_rd1, 32'd9);
`else
    check_val("fwd_wb", ex_if.EX_rd1, 32'd100);
`endif
    // Register $0 is never forwarded
    ID_rs = 5'd0;
    MEM_regwrite = 1'b1; MEM_dst = 5'd0;
    WB_dst = 5'd0;
    step();
    check_val("fwd_r0", ex_if.EX_rd1, 32'd100);

    // Reset mid-stall clears state immediately
    stall = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_valid", 32'(ex_if.EX_valid), 32'd0);
    check_val("rst_mid_rd2", ex_if.EX_rd2, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check_val("rst_mid_hold", 32'(ex_if.EX_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
